prm_edge_mask_acc: RTL and testbench

PRM_EDGE_MASK_ACC -- requirements
Module: prm_edge_mask_acc

---
 rtl/prm_edge_mask_acc.sv | 145 ++++++++++++++
 tb/tb_prm_edge_mask_acc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_acc.sv
// prm_edge_mask_acc: accumulates per-point blocked-edge masks from a
// combinational collision-checker bank into one blocked-edge mask per scan.
// A scan starts on a start pulse, ORs in pt_num accepted point masks and then
// presents the result until the downstream planner takes it.
// Optional feature: define EDGE_MASK_POPCNT_EN to add the blocked_cnt output,
// the number of blocked edges in mask_out.

module prm_edge_mask_acc #(
  parameter int EDGE_NUM = 256,
  parameter int PT_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PT_CNT_W-1:0]           pt_num,
  input  logic                          pt_valid,
  input  logic [EDGE_NUM-1:0]           chk_mask,
  output logic                          pt_ready,
  output logic                          mask_valid,
  input  logic                          mask_ready,
  output logic [EDGE_NUM-1:0]           mask_out,
`ifdef EDGE_MASK_POPCNT_EN
  output logic [$clog2(EDGE_NUM+1)-1:0] blocked_cnt,
`endif
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [PT_CNT_W-1:0] CNT_ONE  = PT_CNT_W'(1);
  localparam logic [PT_CNT_W-1:0] CNT_ZERO = '0;

  state_t                state;
  state_t                state_nxt;
  logic [EDGE_NUM-1:0]   acc;
  logic [EDGE_NUM-1:0]   acc_nxt;
  logic [EDGE_NUM-1:0]   result;
  logic [EDGE_NUM-1:0]   result_nxt;
  logic [PT_CNT_W-1:0]   cnt;
  logic [PT_CNT_W-1:0]   cnt_nxt;
  logic [PT_CNT_W-1:0]   pt_num_q;
  logic [PT_CNT_W-1:0]   pt_num_nxt;
  logic                  accept;
  logic                  last_pt;
  logic [EDGE_NUM-1:0]   merged;

  // A point is taken only while scanning; the final point is the one whose
  // index equals pt_num-1, compared before incrementing so the counter never
  // has to hold a value past pt_num and cannot wrap.
  assign accept  = (state == SCAN) && pt_valid;
  assign last_pt = (cnt == (pt_num_q - CNT_ONE));
  assign merged  = acc | chk_mask;

  // State, accumulator, point counter, latched point count and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      result   <= '0;
      cnt      <= '0;
      pt_num_q <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      result   <= result_nxt;
      cnt      <= cnt_nxt;
      pt_num_q <= pt_num_nxt;
    end
  end

  // Next-state and datapath update; the result register is loaded on the
  // same edge that enters OUT so it equals the final accumulator and then
  // stays put until the next scan completes.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    result_nxt = result;
    cnt_nxt    = cnt;
    pt_num_nxt = pt_num_q;
    case (state)
      IDLE: begin
        if (start) begin
          pt_num_nxt = pt_num;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          if (pt_num == CNT_ZERO) begin
            state_nxt  = OUT;
            result_nxt = '0;
          end else begin
            state_nxt  = SCAN;
          end
        end
      end
      SCAN: begin
        if (accept) begin
          acc_nxt = merged;
          cnt_nxt = cnt + CNT_ONE;
          if (last_pt) begin
            state_nxt  = OUT;
            result_nxt = merged;
          end
        end
      end
      OUT: begin
        if (mask_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status and data outputs, forced quiet while reset is held so nothing
  // downstream sees a stale handshake during the reset cycle itself.
  always_comb begin
    pt_ready   = 1'b0;
    mask_valid = 1'b0;
    busy       = 1'b0;
    mask_out   = '0;
    if (!rst) begin
      pt_ready   = (state == SCAN);
      mask_valid = (state == OUT);
      busy       = (state == SCAN) || (state == OUT);
      mask_out   = result;
    end
  end

`ifdef EDGE_MASK_POPCNT_EN
  // Population count of the presented mask; follows mask_out, so it is zero
  // after reset and valid whenever mask_valid is high.
  always_comb begin
    blocked_cnt = '0;
    for (int i = 0; i < EDGE_NUM; i++) begin
      blocked_cnt = blocked_cnt + {{($clog2(EDGE_NUM+1)-1){1'b0}}, mask_out[i]};
    end
  end
`endif

endmodule

// File: tb/tb_prm_edge_mask_acc.sv
// Directed testbench for prm_edge_mask_acc with EDGE_NUM=8, PT_CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.

module tb_prm_edge_mask_acc;

  localparam int EDGE_NUM = 8;
  localparam int PT_CNT_W = 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic [PT_CNT_W-1:0] pt_num;
  logic                pt_valid;
  logic [EDGE_NUM-1:0] chk_mask;
  logic                pt_ready;
  logic                mask_valid;
  logic                mask_ready;
  logic [EDGE_NUM-1:0] mask_out;
  logic                busy;
`ifdef EDGE_MASK_POPCNT_EN
  logic [$clog2(EDGE_NUM+1)-1:0] blocked_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  prm_edge_mask_acc #(
    .EDGE_NUM(EDGE_NUM),
    .PT_CNT_W(PT_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pt_num     (pt_num),
    .pt_valid   (pt_valid),
    .chk_mask   (chk_mask),
    .pt_ready   (pt_ready),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask_out   (mask_out),
`ifdef EDGE_MASK_POPCNT_EN
    .blocked_cnt(blocked_cnt),
`endif
    .busy       (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set all stimulus inputs in one go.
  task automatic applyStimulus(input logic s, input logic [PT_CNT_W-1:0] n, input logic v,
                               input logic [EDGE_NUM-1:0] m, input logic r);
    start      = s;
    pt_num     = n;
    pt_valid   = v;
    chk_mask   = m;
    mask_ready = r;
  endtask

  task automatic checkCnt(input string tag, input int expected);
`ifdef EDGE_MASK_POPCNT_EN
    checkOutput(tag, 32'(blocked_cnt), 32'(expected));
`endif
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("rst_pt_ready", 32'(pt_ready), 32'd0);
    checkOutput("rst_mask_valid", 32'(mask_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mask_out", 32'(mask_out), 32'd0);
    tick();
    tick();
    checkOutput("rst_mask_out_after", 32'(mask_out), 32'd0);
    checkCnt("rst_blocked_cnt", 0);
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Three points 0x01, 0x10, 0x01 back to back.
    applyStimulus(1'b1, 4'd3, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_pt_ready", 32'(pt_ready), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 8'h01, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1, 8'h10, 1'b0);
    tick();
    checkOutput("t1_valid_early", 32'(mask_valid), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 8'h01, 1'b0);
    tick();
    checkOutput("t1_mask_valid", 32'(mask_valid), 32'd1);
    checkOutput("t1_mask_out", 32'(mask_out), 32'h11);
    checkOutput("t1_pt_ready_out", 32'(pt_ready), 32'd0);
    checkCnt("t1_blocked_cnt", 2);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    checkOutput("t1_idle_valid", 32'(mask_valid), 32'd0);
    checkOutput("t1_hold_last", 32'(mask_out), 32'h11);

    // Zero-point scan goes straight to OUT with an empty mask.
    applyStimulus(1'b1, 4'd0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t2_mask_valid", 32'(mask_valid), 32'd1);
    checkOutput("t2_mask_out", 32'(mask_out), 32'h00);
    checkOutput("t2_pt_ready", 32'(pt_ready), 32'd0);
    checkCnt("t2_blocked_cnt", 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("t2_idle_busy", 32'(busy), 32'd0);

    // Two points with pt_valid gaps and a stray start during SCAN.
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd0, 1'b1, 8'h02, 1'b0);
    tick();
    checkOutput("t3_busy", 32'(busy), 32'd1);
    checkOutput("t3_no_restart", 32'(mask_valid), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'hFF, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 8'hFF, 1'b0);
    tick();
    checkOutput("t3_valid_early", 32'(mask_valid), 32'd0);
    checkOutput("t3_pt_ready", 32'(pt_ready), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 8'h08, 1'b0);
    tick();
    checkOutput("t3_mask_valid", 32'(mask_valid), 32'd1);
    checkOutput("t3_mask_out", 32'(mask_out), 32'h0A);
    checkCnt("t3_blocked_cnt", 2);

    // Back-pressure in OUT: result holds, start and points ignored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd1, 1'b1, 8'hFF, 1'b0);
      tick();
      checkOutput($sformatf("t4_valid_%0d", i), 32'(mask_valid), 32'd1);
      checkOutput($sformatf("t4_mask_%0d", i), 32'(mask_out), 32'h0A);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("t4_idle_busy", 32'(busy), 32'd0);
    checkOutput("t4_idle_valid", 32'(mask_valid), 32'd0);

    // Points offered in IDLE are not accepted.
    applyStimulus(1'b0, 4'd0, 1'b1, 8'hFF, 1'b1);
    tick();
    checkOutput("t5_pt_ready", 32'(pt_ready), 32'd0);
    checkOutput("t5_mask_out", 32'(mask_out), 32'h0A);

    // Reset after one of three points aborts the scan.
    applyStimulus(1'b1, 4'd3, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1, 8'h20, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 4'd1, 1'b1, 8'h40, 1'b1);
    #1;
    checkOutput("t6_rst_busy_now", 32'(busy), 32'd0);
    tick();
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_mask_out", 32'(mask_out), 32'h00);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t6_no_valid", 32'(mask_valid), 32'd0);
    checkOutput("t6_rst_beats_start", 32'(busy), 32'd0);
    applyStimulus(1'b1, 4'd1, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1, 8'h80, 1'b0);
    tick();
    checkOutput("t6_mask_valid", 32'(mask_valid), 32'd1);
    checkOutput("t6_mask_out2", 32'(mask_out), 32'h80);
    checkCnt("t6_blocked_cnt", 1);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    tick();

    // Maximum point count: exactly 15 accepts, no counter wrap.
    applyStimulus(1'b1, 4'd15, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 8'hFF, 1'b0);
      tick();
      checkOutput($sformatf("t7_pending_%0d", i), 32'(mask_valid), 32'd0);
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 8'hFF, 1'b0);
    tick();
    checkOutput("t7_mask_valid", 32'(mask_valid), 32'd1);
    checkOutput("t7_mask_out", 32'(mask_out), 32'hFF);
    checkCnt("t7_blocked_cnt", 8);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("t7_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
